// File: rtl/simon_pkg.sv
// Shared types and display constants for the Simon Says display path.
package simon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        LOSE,
        WIN
    } hex_state_t;

    // Active-low segment patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Chase: one lit outer segment, stepping a -> f
    localparam int unsigned CHASE_LEN   = 6;
    localparam int unsigned CHASE_STEPS = 12;
    localparam logic [6:0] CHASE_SEG [CHASE_LEN] = '{
        7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F
    };

    function automatic logic [6:0] seg(input logic [3:0] v);
        return SEG_FONT[v];
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: pulses tick on the last cycle of every ms-cycle window.
// clear forces the count back to zero so a new window starts next cycle.
module tick_gen #(
    parameter int unsigned ms = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (ms > 1) ? $clog2(ms) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(ms - 1));

    // Next count: wrap on tick, restart on clear
    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hex_status.sv
// HEX0 display stage: level digit during play, flash on loss, chase on win.
// HEX_STATUS_WIN_CHASE_EN: when defined WIN runs a two-revolution segment
// chase; otherwise WIN holds the level digit for two phases.
module hex_status
    import simon_pkg::*;
#(
    parameter int unsigned ms              = 1_000_000,
    parameter int unsigned FLASH_COUNT     = 6,
    parameter int unsigned TICKS_PER_PHASE = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] level,
    input  logic       level_valid,
    input  logic       game_over,
    input  logic       game_won,
    output logic [6:0] hex,
    output logic       anim_done,
    output logic       busy
);

    localparam int unsigned TW     = (TICKS_PER_PHASE > 1) ? $clog2(TICKS_PER_PHASE) : 1;
    localparam int unsigned PH_MAX = (FLASH_COUNT > CHASE_STEPS) ? FLASH_COUNT : CHASE_STEPS;
    localparam int unsigned PW     = $clog2(PH_MAX);
`ifdef HEX_STATUS_WIN_CHASE_EN
    localparam int unsigned WIN_PHASES = CHASE_STEPS;
`else
    localparam int unsigned WIN_PHASES = 2;
`endif

    hex_state_t     state_q, state_d;
    logic [3:0]     level_q, level_d;
    logic [TW-1:0]  tk_q, tk_d;
    logic [PW-1:0]  ph_q, ph_d;
    logic [6:0]     hex_q, hex_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
`ifdef HEX_STATUS_WIN_CHASE_EN
    logic [2:0]     pos_q, pos_d;
`endif

    logic tick;
    logic tick_clear;
    logic phase_end;
    logic anim_end;

    tick_gen #(.ms(ms)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Next-state, phase counting and display selection
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        tk_d     = tk_q;
        ph_d     = ph_q;
        anim_end = 1'b0;
`ifdef HEX_STATUS_WIN_CHASE_EN
        pos_d    = pos_q;
`endif
        phase_end = tick && (tk_q == TW'(TICKS_PER_PHASE - 1));

        case (state_q)
            IDLE, SHOW: begin
                tk_d = '0;
                ph_d = '0;
`ifdef HEX_STATUS_WIN_CHASE_EN
                pos_d = '0;
`endif
                // level is latched even when game_over wins the priority
                if (level_valid) begin
                    level_d = level;
                end
                if (game_over) begin
                    state_d = LOSE;
                end else if (game_won) begin
                    state_d = WIN;
                end else if (level_valid) begin
                    state_d = SHOW;
                end
            end
            LOSE: begin
                if (phase_end) begin
                    tk_d = '0;
                    if (ph_q == PW'(FLASH_COUNT - 1)) begin
                        state_d  = IDLE;
                        anim_end = 1'b1;
                        ph_d     = '0;
                    end else begin
                        ph_d = ph_q + PW'(1);
                    end
                end else if (tick) begin
                    tk_d = tk_q + TW'(1);
                end
            end
            WIN: begin
                if (phase_end) begin
                    tk_d = '0;
`ifdef HEX_STATUS_WIN_CHASE_EN
                    pos_d = (pos_q == 3'(CHASE_LEN - 1)) ? '0 : pos_q + 3'd1;
`endif
                    if (ph_q == PW'(WIN_PHASES - 1)) begin
                        state_d  = IDLE;
                        anim_end = 1'b1;
                        ph_d     = '0;
`ifdef HEX_STATUS_WIN_CHASE_EN
                        pos_d    = '0;
`endif
                    end else begin
                        ph_d = ph_q + PW'(1);
                    end
                end else if (tick) begin
                    tk_d = tk_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Prescaler runs only inside an animation so each phase starts aligned
        tick_clear = !((state_q == LOSE) || (state_q == WIN)) || anim_end;

        done_d = anim_end;
        busy_d = (state_d == LOSE) || (state_d == WIN);

        // Display follows the next state so hex changes with the state edge
        case (state_d)
            IDLE:    hex_d = SEG_DASH;
            SHOW:    hex_d = seg(level_d);
            LOSE:    hex_d = ph_d[0] ? SEG_BLANK : seg(level_d);
`ifdef HEX_STATUS_WIN_CHASE_EN
            WIN:     hex_d = CHASE_SEG[pos_d];
`else
            WIN:     hex_d = seg(level_d);
`endif
            default: hex_d = SEG_DASH;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= '0;
            tk_q    <= '0;
            ph_q    <= '0;
            hex_q   <= SEG_DASH;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef HEX_STATUS_WIN_CHASE_EN
            pos_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            tk_q    <= tk_d;
            ph_q    <= ph_d;
            hex_q   <= hex_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef HEX_STATUS_WIN_CHASE_EN
            pos_q   <= pos_d;
`endif
        end
    end

    assign hex       = hex_q;
    assign anim_done = done_q;
    assign busy      = busy_q;

endmodule

// File: doc/hex_status.md
# hex_status

Downstream display stage for the Simon Says game. It consumes the level counter and the game-outcome strobes produced by the game FSM and drives the single active-low seven-segment digit (HEX0), which the top level currently leaves unused. The block shows the current level as a hex digit during play. It plays a timed flash or chase animation on loss or win, then signals completion so the FSM can restart.

## Interface
- `ms`, default 1_000_000: clock cycles per animation tick. Must be ≥ 2.
- `FLASH_COUNT`, default 6: number of lit/blank half-periods in the LOSE animation. Must be ≥ 1.
- `TICKS_PER_PHASE`, default 25: ticks per half-period (LOSE) or per segment step (WIN chase).
- `clk` input, 1 bit: system clock (CLOCK_50).
- `reset` input, 1 bit: asynchronous, active-high. Clears all state.
- `level` input, 4 bits: current level/address from the FSM. Sampled only on `level_valid`.
- `level_valid` input, 1 bit: one-cycle strobe; `level` holds a new value.
- `game_over` input, 1 bit: one-cycle strobe; the player entered a wrong input.
- `game_won` input, 1 bit: one-cycle strobe; the maximum level was completed.
- `hex` output, 7 bits: segment drive, active-low; bit0 = a … bit6 = g. Registered.
- `anim_done` output, 1 bit: one-cycle pulse when a LOSE or WIN animation ends.
- `busy` output, 1 bit: high while in LOSE or WIN.

## Operation
- States:
  - IDLE: shows dash, `7'b0111111`.
  - SHOW: shows `seg(level_q)`.
  - LOSE: flashes `seg(level_q)` alternating with blank, `7'h7F`.
  - WIN: chase animation.
- Reset values: state=IDLE, `hex`=dash, `level_q`=0, `anim_done`=0, `busy`=0, all counters 0.
- IDLE/SHOW on `level_valid`: latch `level` into `level_q`, go to SHOW. A repeated `level_valid` in SHOW updates the digit.
- IDLE/SHOW on `game_over`: go to LOSE. Phase 0 is lit.
- IDLE/SHOW on `game_won`: go to WIN at segment a.
- Priority for simultaneous strobes: `game_over` > `game_won` > `level_valid`. The lower-priority strobes are dropped. If `game_over` and `level_valid` coincide, `level` is still latched, so LOSE flashes the new level.
- LOSE:
  - Each phase lasts `TICKS_PER_PHASE` ticks. The display toggles lit/blank after each phase.
  - After `FLASH_COUNT` phases: pulse `anim_done`, go to IDLE.
- WIN: the lit segment steps a→b→c→d→e→f→a, one step per `TICKS_PER_PHASE` ticks. After 12 steps (two revolutions): pulse `anim_done`, go to IDLE.
- While `busy` is high, all three input strobes are ignored.
- `seg()` is the standard 0–F hex font: 0=`7'h40`, 1=`7'h79`, 2=`7'h24`, …, 9=`7'h10`, A=`7'h08`, F=`7'h0E`.
- Asserting `reset` mid-animation aborts it immediately with no `anim_done` pulse.

## Timing
- Tick generator: counter 0..ms-1, `tick` pulses on the ms-1 cycle. The counter and phase counter clear on every state entry, so the first phase is exactly `ms*TICKS_PER_PHASE` cycles.
- Counter widths are `$clog2` of their maxima. No wrap occurs inside a phase.
- Event→`hex` latency: 1 cycle. The strobe is sampled at edge N and `hex` changes after edge N.
- LOSE total duration: `FLASH_COUNT*TICKS_PER_PHASE*ms` cycles from entry to the `anim_done` cycle.
- `anim_done`:
  - High for exactly the cycle in which state returns to IDLE, and `hex` shows dash in that same cycle.
  - A strobe arriving in that cycle is accepted; IDLE rules apply.
- `busy` is registered and rises with the state change into LOSE/WIN.

## Configuration
- `HEX_STATUS_WIN_CHASE_EN`
  - Defined: WIN runs the segment chase described above.
  - Undefined: WIN shows `seg(level_q)` steadily for `2*TICKS_PER_PHASE` ticks, then pulses `anim_done`. The chase step counter is not built.

## Structure
- Package `simon_pkg` holds:
  - `hex_state_t` enum {IDLE, SHOW, LOSE, WIN};
  - `SEG_DASH` and `SEG_BLANK` constants;
  - the 16-entry `SEG_FONT` array;
  - the chase sequence constants.
- Sub-module `tick_gen #(ms)` contains the prescaler. Ports: `clk`, `reset`, `clear`, `tick`. It is reusable by the blinker.

## Test plan
Benches use ms=4, TICKS_PER_PHASE=2, FLASH_COUNT=3.
- Reset → `hex`=`7'h3F`, `busy`=0, `anim_done`=0; the values hold with no strobes.
- `level_valid` with level=4'hA → `hex`=`7'h08` one cycle later; then level=3 → `7'h30`.
- `game_over` in SHOW(level 2) → `hex` sequence per 8-cycle phase: `7'h24`, `7'h7F`, `7'h24`. Then `anim_done` pulses for 1 cycle at cycle 24 and `hex`=dash.
- `game_won` with `HEX_STATUS_WIN_CHASE_EN` → single active-low segment a,b,…,f,a… each held 8 cycles, 12 steps. `anim_done` pulses at cycle 96.
- `game_over`+`game_won`+`level_valid` (level=5) in the same cycle → LOSE flashing `7'h12`; strobes arriving while `busy` are ignored.
- `reset` asserted mid-LOSE → `hex`=dash immediately (asynchronously), no `anim_done` pulse, and a `level_valid` after deassertion works normally.
